// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, mul/div FSM states
// and the register-index width used by the hazard logic.
package pipeline_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    // M stage wins over W; r0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic             reg_write_m,
        input logic [REG_W-1:0] write_reg_m,
        input logic             reg_write_w,
        input logic [REG_W-1:0] write_reg_w,
        input logic [REG_W-1:0] src
    );
        if (reg_write_m && (write_reg_m != '0) && (write_reg_m == src)) begin
            return FWD_M;
        end else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == src)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Tracks occupancy of the multi-cycle mul/div unit: busy for MD_LATENCY-1
// cycles after an issue, counting down to one before returning to idle.
module md_sequencer
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_i,
    output logic md_busy_o
);

    localparam int unsigned CntW = $clog2(MD_LATENCY);

    md_state_t           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CntW'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                // A start while busy is a protocol error; it neither reloads nor extends.
                if (cnt_q == CntW'(1)) begin
                    state_d = MD_IDLE;
                end
                cnt_d = cnt_q - CntW'(1);
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load/branch/
// mul-div stalls, IF/ID flush and a saturating stall-cycle counter.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             PCSrcD,
    input  logic             MdOpD,
    input  logic             MdStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCount
);

    logic             md_busy;
    logic             lw_stall, branch_stall, md_stall, stall;
    logic             e_hits_d, m_hits_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    md_sequencer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_sequencer (
        .clk        (clk),
        .rst        (rst),
        .md_start_i (MdStartE),
        .md_busy_o  (md_busy)
    );

    always_comb begin
        e_hits_d     = RegWriteE && (WriteRegE != '0) &&
                       ((WriteRegE == RsD) || (WriteRegE == RtD));
        m_hits_d     = MemtoRegM && (WriteRegM != '0) &&
                       ((WriteRegM == RsD) || (WriteRegM == RtD));
        lw_stall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
        branch_stall = BranchD && (e_hits_d || m_hits_d);
        md_stall     = MdOpD && md_busy;
        stall        = lw_stall || branch_stall || md_stall;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    // Everything is held low during the reset cycle.
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushE     = 1'b0;
        FlushD     = 1'b0;
        ForwardAD  = 1'b0;
        ForwardBD  = 1'b0;
        ForwardAE  = FWD_RF;
        ForwardBE  = FWD_RF;
        MdBusy     = 1'b0;
        StallCount = '0;
        if (!rst) begin
            StallF     = stall;
            StallD     = stall;
            FlushE     = stall;
            // A stalled branch would flush on stale compare data.
            FlushD     = (PCSrcD || JumpD) && !stall;
            ForwardAD  = RegWriteM && (WriteRegM != '0) && (WriteRegM == RsD);
            ForwardBD  = RegWriteM && (WriteRegM != '0) && (WriteRegM == RtD);
            ForwardAE  = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE);
            ForwardBE  = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RtE);
            MdBusy     = md_busy;
            StallCount = stall_count_q;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a table of combinational vectors
// plus hand-written multi-cycle sequences, checked through an expected queue.
module tb_hazard_controller;

    localparam int unsigned MdLat = 4;
    localparam int unsigned CntW  = 2;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, m2r_e, m2r_m;
        logic       branch, jump, pcsrc, mdop, mdstart;
        logic [1:0] fae, fbe;
        logic       fad, fbd, stall, flush_d, busy;
        logic       chk_cnt;
        logic [1:0] cnt;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic            RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic            BranchD, JumpD, PCSrcD, MdOpD, MdStartE;
    logic            StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [CntW-1:0] StallCount;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_controller #(
        .MD_LATENCY (MdLat),
        .CNT_W      (CntW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RsD        (RsD),
        .RtD        (RtD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .WriteRegM  (WriteRegM),
        .WriteRegW  (WriteRegW),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemtoRegE  (MemtoRegE),
        .MemtoRegM  (MemtoRegM),
        .BranchD    (BranchD),
        .JumpD      (JumpD),
        .PCSrcD     (PCSrcD),
        .MdOpD      (MdOpD),
        .MdStartE   (MdStartE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAD  (ForwardAD),
        .ForwardBD  (ForwardBD),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MdBusy     (MdBusy),
        .StallCount (StallCount)
    );

    // Drive one cycle of stimulus just after posedge, check on the following negedge.
    task automatic step(input vec_t v, input string name);
        vec_t        e;
        logic [10:0] act, exp_o;
        @(posedge clk);
        #1;
        rst = v.rst;
        RsD = v.rs_d; RtD = v.rt_d; RsE = v.rs_e; RtE = v.rt_e;
        WriteRegE = v.wr_e; WriteRegM = v.wr_m; WriteRegW = v.wr_w;
        RegWriteE = v.rw_e; RegWriteM = v.rw_m; RegWriteW = v.rw_w;
        MemtoRegE = v.m2r_e; MemtoRegM = v.m2r_m;
        BranchD = v.branch; JumpD = v.jump; PCSrcD = v.pcsrc;
        MdOpD = v.mdop; MdStartE = v.mdstart;
        sb.push_back(v);
        @(negedge clk);
        e     = sb.pop_front();
        act   = {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE,
                 FlushD, MdBusy};
        exp_o = {e.fae, e.fbe, e.fad, e.fbd, e.stall, e.stall, e.stall, e.flush_d, e.busy};
        n_total++;
        if (act === exp_o) n_pass++;
        else $display("FAIL %s: outputs got %b expected %b (AE BE AD BD SF SD FE FD busy)",
                      name, act, exp_o);
        if (e.chk_cnt) begin
            n_total++;
            if (StallCount === e.cnt) n_pass++;
            else $display("FAIL %s: StallCount got %0d expected %0d", name, StallCount, e.cnt);
        end
    endtask

    function automatic vec_t z();
        vec_t v;
        v = '0;
        return v;
    endfunction

    initial begin
        vec_t v;

        // Reset cycle with a load-use hazard present: everything must read zero.
        v = z(); v.rst = 1; v.m2r_e = 1; v.rt_e = 9; v.rs_d = 9; v.rw_m = 1; v.wr_m = 9;
        v.rs_e = 9; v.chk_cnt = 1;
        step(v, "reset_outputs");

        // Combinational table.
        v = z(); v.rw_m = 1; v.wr_m = 8; v.rs_e = 8; v.rw_w = 1; v.wr_w = 8; v.fae = 2'b10;
        tbl.push_back(v);
        v = z(); v.rw_m = 1; v.wr_m = 0; v.rs_e = 0; v.rw_w = 1; v.wr_w = 0;
        tbl.push_back(v);
        v = z(); v.rw_w = 1; v.wr_w = 5; v.rs_e = 5; v.rt_e = 5; v.rw_m = 1; v.wr_m = 6;
        v.fae = 2'b01; v.fbe = 2'b01;
        tbl.push_back(v);
        v = z(); v.rw_m = 1; v.wr_m = 7; v.rw_w = 1; v.wr_w = 7; v.rs_e = 7; v.rt_e = 7;
        v.rs_d = 7; v.rt_d = 3; v.fae = 2'b10; v.fbe = 2'b10; v.fad = 1;
        tbl.push_back(v);
        v = z(); v.rw_m = 0; v.wr_m = 8; v.rs_e = 8; v.rw_w = 1; v.wr_w = 8; v.fae = 2'b01;
        tbl.push_back(v);
        v = z(); v.m2r_e = 1; v.rt_e = 9; v.rs_d = 9; v.rt_d = 1; v.rs_e = 1; v.stall = 1;
        tbl.push_back(v);
        v = z(); v.m2r_e = 1; v.rt_e = 10; v.rt_d = 10; v.rs_d = 2; v.stall = 1;
        tbl.push_back(v);
        v = z(); v.m2r_e = 0; v.rt_e = 9; v.rs_d = 9;
        tbl.push_back(v);
        v = z(); v.branch = 1; v.pcsrc = 1; v.rs_d = 3; v.rt_d = 4; v.rw_e = 1; v.wr_e = 5;
        v.flush_d = 1;
        tbl.push_back(v);
        v = z(); v.branch = 1; v.pcsrc = 1; v.rs_d = 4; v.rt_d = 2; v.rw_e = 1; v.wr_e = 4;
        v.stall = 1;
        tbl.push_back(v);
        v = z(); v.branch = 1; v.pcsrc = 1; v.m2r_m = 1; v.rw_m = 1; v.wr_m = 6; v.rt_d = 6;
        v.rs_d = 1; v.fbd = 1; v.stall = 1;
        tbl.push_back(v);
        v = z(); v.jump = 1; v.rs_d = 1; v.flush_d = 1;
        tbl.push_back(v);
        v = z(); v.branch = 1; v.pcsrc = 1; v.rw_e = 1; v.wr_e = 0; v.rs_d = 0; v.rt_d = 0;
        v.flush_d = 1;
        tbl.push_back(v);
        foreach (tbl[i]) step(tbl[i], $sformatf("table_%0d", i));

        // Single load-use stall: counter 0 -> 1.
        v = z(); v.rst = 1; step(v, "rst_a");
        v = z(); v.m2r_e = 1; v.rt_e = 9; v.rs_d = 9; v.rt_d = 1; v.stall = 1; v.chk_cnt = 1;
        v.cnt = 0; step(v, "lw_stall_cycle");
        v = z(); v.rs_d = 1; v.rt_d = 2; v.chk_cnt = 1; v.cnt = 1; step(v, "lw_released");

        // Stalled taken branch, then E clears and M forwards to the compare.
        v = z(); v.branch = 1; v.pcsrc = 1; v.rw_e = 1; v.wr_e = 4; v.rs_d = 4; v.rt_d = 2;
        v.stall = 1; step(v, "branch_stalled");
        v = z(); v.branch = 1; v.pcsrc = 1; v.rw_m = 1; v.wr_m = 4; v.rs_d = 4; v.rt_d = 2;
        v.fad = 1; v.flush_d = 1; step(v, "branch_resolved");

        // Mul/div occupancy with HI/LO interlock.
        v = z(); v.rst = 1; step(v, "rst_b");
        v = z(); v.mdstart = 1; v.mdop = 1; v.chk_cnt = 1; v.cnt = 0; step(v, "md_t0");
        for (int t = 1; t <= 3; t++) begin
            v = z(); v.mdop = 1; v.busy = 1; v.stall = 1; v.chk_cnt = 1; v.cnt = 2'(t - 1);
            step(v, $sformatf("md_t%0d", t));
        end
        v = z(); v.mdop = 1; v.chk_cnt = 1; v.cnt = 3; step(v, "md_t4");

        // Reset while busy.
        v = z(); v.rst = 1; step(v, "rst_c");
        v = z(); v.mdstart = 1; step(v, "mdr_t0");
        v = z(); v.mdop = 1; v.busy = 1; v.stall = 1; v.chk_cnt = 1; v.cnt = 0;
        step(v, "mdr_t1");
        v = z(); v.rst = 1; v.mdop = 1; v.chk_cnt = 1; v.cnt = 0; step(v, "mdr_t2_rst");
        v = z(); v.mdop = 1; v.chk_cnt = 1; v.cnt = 0; step(v, "mdr_t3_idle");

        // A second start while busy must not extend occupancy.
        v = z(); v.mdstart = 1; step(v, "mdx_t0");
        v = z(); v.mdstart = 1; v.busy = 1; step(v, "mdx_t1_restart");
        v = z(); v.busy = 1; step(v, "mdx_t2");
        v = z(); v.busy = 1; step(v, "mdx_t3");
        v = z(); step(v, "mdx_t4_idle");

        // Saturation of the 2-bit stall counter.
        v = z(); v.rst = 1; step(v, "rst_d");
        for (int t = 0; t < 6; t++) begin
            v = z(); v.m2r_e = 1; v.rt_e = 3; v.rt_d = 3; v.rs_d = 1; v.stall = 1;
            v.chk_cnt = 1; v.cnt = (t > 3) ? 2'd3 : 2'(t);
            step(v, $sformatf("sat_%0d", t));
        end
        v = z(); v.rs_d = 1; v.chk_cnt = 1; v.cnt = 3; step(v, "sat_hold");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
